// File: rtl/taxi_pkg.sv
// Shared taxi types and default sizing used by the mileage meter and the fare block.
package taxi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } trip_state_t;

  localparam int DIST_W_DEF        = 16;
  localparam int PULSES_PER_KM_DEF = 1000;
  localparam int STOP_CYCLES_DEF   = 50_000_000;

endpackage

// File: rtl/pulse_sync.sv
// Brings an asynchronous level into the clk domain and emits a registered
// one-cycle strobe for each rising edge; reusable for button inputs.
module pulse_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse_rise
);

  logic sync1;
  logic sync2;
  logic sync3;

  // sync1/sync2 resolve metastability, sync3 holds the previous level for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      pulse_rise <= 1'b0;
    end else begin
      sync1      <= async_in;
      sync2      <= sync1;
      sync3      <= sync2;
      pulse_rise <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/mileage_meter.sv
// Trip state machine that turns wheel pulses into whole kilometres and
// reports whether the car is moving; feeds distance and stop to the fare block.
module mileage_meter
  import taxi_pkg::*;
#(
  parameter int PULSES_PER_KM = PULSES_PER_KM_DEF,
  parameter int STOP_CYCLES   = STOP_CYCLES_DEF,
  parameter int DIST_W        = DIST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wheel_pulse,
  input  logic              trip_start,
  input  logic              trip_end,
  input  logic              trip_clear,
  output logic [DIST_W-1:0] distence,
  output logic              car_stop,
  output logic              moving,
  output logic              trip_done
);

  localparam int SUB_W  = $clog2(PULSES_PER_KM);
  localparam int IDLE_W = $clog2(STOP_CYCLES);

  localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(PULSES_PER_KM - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(STOP_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_PRELAST = IDLE_W'(STOP_CYCLES - 2);

  trip_state_t       state;
  trip_state_t       next_state;
  logic              pulse_rise;
  logic              restart;
  logic              count_en;
  logic [SUB_W-1:0]  sub_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  pulse_sync u_wheel_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (wheel_pulse),
    .pulse_rise (pulse_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Strobe priority is clear > end > start; a pulse only counts in a RUN cycle with no strobe.
  always_comb begin
    next_state = state;
    restart    = 1'b0;
    count_en   = 1'b0;
    case (state)
      IDLE: begin
        if (!trip_clear && trip_start) begin
          next_state = RUN;
          restart    = 1'b1;
        end
      end
      RUN: begin
        if (trip_clear) begin
          next_state = IDLE;
        end else if (trip_end) begin
          next_state = HOLD;
        end else if (trip_start) begin
          restart = 1'b1;
        end else begin
          count_en = pulse_rise;
        end
      end
      HOLD: begin
        if (trip_clear) begin
          next_state = IDLE;
        end else if (!trip_end && trip_start) begin
          next_state = RUN;
          restart    = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Distance saturates at all-ones while the sub-km counter keeps wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_cnt  <= '0;
      distence <= '0;
    end else if (restart || next_state == IDLE) begin
      sub_cnt  <= '0;
      distence <= '0;
    end else if (count_en) begin
      if (sub_cnt == SUB_LAST) begin
        sub_cnt <= '0;
        if (distence != '1) begin
          distence <= distence + 1'b1;
        end
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_stop  <= 1'b1;
      trip_done <= 1'b0;
    end else begin
      car_stop  <= (next_state == IDLE);
      trip_done <= (state == RUN) && (next_state == HOLD);
    end
  end

  // moving falls on the same edge idle_cnt lands on its saturation value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      moving   <= 1'b0;
    end else if (next_state != RUN || restart) begin
      idle_cnt <= '0;
      moving   <= 1'b0;
    end else if (count_en) begin
      idle_cnt <= '0;
      moving   <= 1'b1;
    end else if (idle_cnt != IDLE_LAST) begin
      idle_cnt <= idle_cnt + 1'b1;
      moving   <= moving && (idle_cnt != IDLE_PRELAST);
    end
  end

endmodule
